// File: rtl/sha_pass_sequencer_if.sv
// Handshake bundle between the mining controller, the header RAM and the pass sequencer.
// master = controller/RAM side, slave = sequencer side.
interface sha_pass_sequencer_if;
    logic        start;
    logic        stop;
    logic [31:0] nonce_init;
    logic [4:0]  hdr_addr;
    logic [31:0] hdr_word;
    logic [1:0]  block;
    logic [6:0]  select;
    logic [31:0] msg_out;
    logic        busy;
    logic        done;
    logic [31:0] nonce_cur;
    logic        wrapped;

    modport master (
        output start, stop, nonce_init, hdr_word,
        input  hdr_addr, block, select, msg_out, busy, done, nonce_cur, wrapped
    );

    modport slave (
        input  start, stop, nonce_init, hdr_word,
        output hdr_addr, block, select, msg_out, busy, done, nonce_cur, wrapped
    );
endinterface

// File: rtl/sha_pass_sequencer.sv
// Sequences the three SHA-256 passes of a Bitcoin double hash into the hash core.
// Optional NONCE_SWEEP_EN: keep hashing with nonce+1 until stopped or the nonce space wraps.
module sha_pass_sequencer (
    input  logic                  clk,
    input  logic                  rst,
    sha_pass_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {IDLE, PRE, ROUND, WB} state_t;

    state_t      state_reg;
    logic [1:0]  pass_reg;
    logic [6:0]  select_reg;
    logic [4:0]  hdr_addr_reg;
    logic [31:0] nonce_reg;
    logic        busy_reg;
    logic        done_reg;
    logic        stop_reg;
    logic        use_ram_reg;
    logic [31:0] msg_const_reg;
`ifdef NONCE_SWEEP_EN
    logic        wrapped_reg;
`endif

    logic [5:0]  t_next;
    logic [4:0]  last_addr;
    logic        addr_advance;
    logic        stop_now;

    // Word source for round t of pass p: header RAM or a locally generated constant.
    function automatic logic from_ram(input logic [1:0] p, input logic [5:0] t);
        return ((p == 2'd0) && (t < 6'd16)) || ((p == 2'd1) && (t < 6'd3));
    endfunction

    function automatic logic [31:0] pad_word(input logic [1:0] p, input logic [5:0] t,
                                             input logic [31:0] n);
        logic [31:0] w;
        w = 32'h0;
        if (p == 2'd1) begin
            case (t)
                6'd3:    w = n;
                6'd4:    w = 32'h8000_0000;
                6'd15:   w = 32'h0000_0280;
                default: w = 32'h0;
            endcase
        end
        return w;
    endfunction

    always_comb begin
        t_next = (state_reg == PRE) ? 6'd0 : (select_reg[5:0] + 6'd1);
        case (pass_reg)
            2'd0:    last_addr = 5'd15;
            2'd1:    last_addr = 5'd18;
            default: last_addr = 5'd0;
        endcase
        addr_advance = (pass_reg != 2'd2) && (hdr_addr_reg != last_addr);
        stop_now     = stop_reg | bus.stop;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            pass_reg      <= 2'd0;
            select_reg    <= 7'd127;
            hdr_addr_reg  <= 5'd0;
            nonce_reg     <= 32'h0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
            stop_reg      <= 1'b0;
            use_ram_reg   <= 1'b0;
            msg_const_reg <= 32'h0;
`ifdef NONCE_SWEEP_EN
            wrapped_reg   <= 1'b0;
`endif
        end else begin
            done_reg <= 1'b0;
            if (state_reg != IDLE && bus.stop)
                stop_reg <= 1'b1;

            case (state_reg)
                IDLE: begin
                    select_reg <= 7'd127;
                    if (bus.start) begin
                        state_reg    <= PRE;
                        pass_reg     <= 2'd0;
                        hdr_addr_reg <= 5'd0;
                        nonce_reg    <= bus.nonce_init;
                        busy_reg     <= 1'b1;
                        stop_reg     <= 1'b0;
`ifdef NONCE_SWEEP_EN
                        wrapped_reg  <= 1'b0;
`endif
                    end
                end

                PRE: begin
                    state_reg     <= ROUND;
                    select_reg    <= 7'd0;
                    use_ram_reg   <= from_ram(pass_reg, t_next);
                    msg_const_reg <= pad_word(pass_reg, t_next, nonce_reg);
                    if (addr_advance)
                        hdr_addr_reg <= hdr_addr_reg + 5'd1;
                end

                ROUND: begin
                    if (select_reg == 7'd63) begin
                        state_reg     <= WB;
                        select_reg    <= 7'd64;
                        use_ram_reg   <= 1'b0;
                        msg_const_reg <= 32'h0;
                        done_reg      <= (pass_reg == 2'd2) && !stop_now;
                    end else begin
                        select_reg    <= select_reg + 7'd1;
                        use_ram_reg   <= from_ram(pass_reg, t_next);
                        msg_const_reg <= pad_word(pass_reg, t_next, nonce_reg);
                        if (addr_advance)
                            hdr_addr_reg <= hdr_addr_reg + 5'd1;
                    end
                end

                WB: begin
                    select_reg <= 7'd127;
                    stop_reg   <= 1'b0;
                    if (stop_now) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end else if (pass_reg != 2'd2) begin
                        state_reg    <= PRE;
                        pass_reg     <= pass_reg + 2'd1;
                        hdr_addr_reg <= (pass_reg == 2'd0) ? 5'd16 : 5'd0;
                    end else begin
`ifdef NONCE_SWEEP_EN
                        // The last nonce of the space ends the sweep instead of rolling over.
                        if (nonce_reg == 32'hFFFF_FFFF) begin
                            state_reg   <= IDLE;
                            busy_reg    <= 1'b0;
                            wrapped_reg <= 1'b1;
                        end else begin
                            state_reg    <= PRE;
                            pass_reg     <= 2'd0;
                            hdr_addr_reg <= 5'd0;
                            nonce_reg    <= nonce_reg + 32'd1;
                        end
`else
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
`endif
                    end
                end

                default: state_reg <= IDLE;
            endcase
        end
    end

    // RAM data has one cycle of latency, so header words pass straight through to the core.
    assign bus.msg_out   = use_ram_reg ? bus.hdr_word : msg_const_reg;
    assign bus.block     = pass_reg;
    assign bus.select    = select_reg;
    assign bus.hdr_addr  = hdr_addr_reg;
    assign bus.busy      = busy_reg;
    assign bus.done      = done_reg;
    assign bus.nonce_cur = nonce_reg;
`ifdef NONCE_SWEEP_EN
    assign bus.wrapped   = wrapped_reg;
`else
    assign bus.wrapped   = 1'b0;
`endif

endmodule

// File: tb/tb_sha_pass_sequencer.sv
// Directed, scoreboard-based bench for sha_pass_sequencer; cycle 1 is the cycle after start acceptance.
module tb_sha_pass_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sha_pass_sequencer_if bus_if();

    sha_pass_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    logic [31:0] ram [0:31];
    always @(posedge clk) bus_if.hdr_word <= ram[bus_if.hdr_addr];

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q [$];
    logic [4:0]  prev_addr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected pass-0 and pass-1 message words for one double hash.
    task automatic push_hash(input logic [31:0] n);
        for (int k = 0; k < 16; k++) exp_q.push_back(32'hA000_0000 + 32'(k));
        exp_q.push_back(32'hA000_0010);
        exp_q.push_back(32'hA000_0011);
        exp_q.push_back(32'hA000_0012);
        exp_q.push_back(n);
        exp_q.push_back(32'h8000_0000);
        for (int k = 0; k < 10; k++) exp_q.push_back(32'h0);
        exp_q.push_back(32'h0000_0280);
    endtask

    // Check one cycle h (1..198) of a running double hash, sampled at negedge.
    task automatic check_cycle(input int h, input logic [31:0] n, input bit exp_done);
        int p, r, t;
        logic [31:0] exp_sel, e;
        p = (h - 1) / 66;
        r = (h - 1) % 66;
        exp_sel = (r == 0) ? 32'd127 : (r == 65) ? 32'd64 : 32'(r - 1);
        check($sformatf("select h=%0d", h), 32'(bus_if.select), exp_sel);
        check($sformatf("block h=%0d", h), 32'(bus_if.block), 32'(p));
        check($sformatf("busy h=%0d", h), 32'(bus_if.busy), 32'd1);
        check($sformatf("done h=%0d", h), 32'(bus_if.done), 32'(exp_done && h == 198));
        check($sformatf("nonce_cur h=%0d", h), bus_if.nonce_cur, n);
        if (r >= 1 && r <= 64) begin
            t = r - 1;
            if (p < 2 && t < 16) begin
                check($sformatf("sb_avail h=%0d", h), 32'(exp_q.size() > 0), 32'd1);
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
                check($sformatf("msg p=%0d t=%0d", p, t), bus_if.msg_out, e);
                if (p == 0 || t < 3)
                    check($sformatf("addr_lead p=%0d t=%0d", p, t), 32'(prev_addr), 32'(p * 16 + t));
            end else begin
                check($sformatf("msg_zero p=%0d t=%0d", p, t), bus_if.msg_out, 32'h0);
            end
        end else if (r == 65) begin
            check($sformatf("msg_wb p=%0d", p), bus_if.msg_out, 32'h0);
        end
        prev_addr = bus_if.hdr_addr;
        $display("cycle h=%0d pass=%0d sel=%0d msg=%h addr=%0d done=%0b", h, bus_if.block,
                 bus_if.select, bus_if.msg_out, bus_if.hdr_addr, bus_if.done);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " select"}, 32'(bus_if.select), 32'd127);
        check({tag, " busy"}, 32'(bus_if.busy), 32'd0);
        check({tag, " block"}, 32'(bus_if.block), 32'd0);
        check({tag, " msg_out"}, bus_if.msg_out, 32'h0);
        check({tag, " hdr_addr"}, 32'(bus_if.hdr_addr), 32'd0);
        check({tag, " done"}, 32'(bus_if.done), 32'd0);
        check({tag, " nonce_cur"}, bus_if.nonce_cur, 32'h0);
        check({tag, " wrapped"}, 32'(bus_if.wrapped), 32'd0);
    endtask

    initial begin
        for (int k = 0; k < 32; k++) ram[k] = 32'hA000_0000 + 32'(k);
        bus_if.start      = 1'b0;
        bus_if.stop       = 1'b0;
        bus_if.nonce_init = 32'h0;
        prev_addr         = 5'd0;

        // Reset state, during and after reset.
        repeat (2) @(negedge clk);
        check_reset_outputs("in_reset");
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("after_reset");

        // Single double hash.
        push_hash(32'h1234_5678);
        bus_if.nonce_init = 32'h1234_5678;
        bus_if.start      = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        for (int h = 1; h <= 198; h++) begin
            check_cycle(h, 32'h1234_5678, 1'b1);
            @(negedge clk);
        end
        check("single sb_empty", 32'(exp_q.size()), 32'd0);
`ifdef NONCE_SWEEP_EN
        check("single sweep busy", 32'(bus_if.busy), 32'd1);
        check("single sweep nonce", bus_if.nonce_cur, 32'h1234_5679);
        check("single sweep select", 32'(bus_if.select), 32'd127);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
`else
        check("single end busy", 32'(bus_if.busy), 32'd0);
        check("single end done", 32'(bus_if.done), 32'd0);
        check("single end select", 32'(bus_if.select), 32'd127);
        check("single end nonce", bus_if.nonce_cur, 32'h1234_5678);
        check("single end wrapped", 32'(bus_if.wrapped), 32'd0);
`endif

        // Asynchronous reset in pass 1, select 30.
        push_hash(32'h0BAD_F00D);
        bus_if.nonce_init = 32'h0BAD_F00D;
        bus_if.start      = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        for (int h = 1; h <= 97; h++) begin
            check_cycle(h, 32'h0BAD_F00D, 1'b1);
            @(negedge clk);
        end
        check_cycle(98, 32'h0BAD_F00D, 1'b1);
        rst = 1'b1;
        #1;
        check_reset_outputs("midrun_reset");
        @(negedge clk);
        rst = 1'b0;
        check("reset sb_empty", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < 250; i++) begin
            @(negedge clk);
            check($sformatf("post_reset done i=%0d", i), 32'(bus_if.done), 32'd0);
            check($sformatf("post_reset busy i=%0d", i), 32'(bus_if.busy), 32'd0);
        end

        // Stop in pass 1 select 10: abort at pass-1 WB with no done.
        push_hash(32'hCAFE_0001);
        bus_if.nonce_init = 32'hCAFE_0001;
        bus_if.start      = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        for (int h = 1; h <= 77; h++) begin
            check_cycle(h, 32'hCAFE_0001, 1'b0);
            @(negedge clk);
        end
        check_cycle(78, 32'hCAFE_0001, 1'b0);
        bus_if.stop = 1'b1;
        @(negedge clk);
        bus_if.stop = 1'b0;
        for (int h = 79; h <= 132; h++) begin
            check_cycle(h, 32'hCAFE_0001, 1'b0);
            @(negedge clk);
        end
        check("stop c133 busy", 32'(bus_if.busy), 32'd0);
        check("stop c133 select", 32'(bus_if.select), 32'd127);
        check("stop sb_empty", 32'(exp_q.size()), 32'd0);
        for (int i = 0; i < 70; i++) begin
            check($sformatf("stop no_done i=%0d", i), 32'(bus_if.done), 32'd0);
            check($sformatf("stop idle i=%0d", i), 32'(bus_if.busy), 32'd0);
            @(negedge clk);
        end

`ifndef NONCE_SWEEP_EN
        // start held high: ignored while busy, re-accepted right after done with a fresh nonce.
        push_hash(32'h1111_1111);
        bus_if.nonce_init = 32'h1111_1111;
        bus_if.start      = 1'b1;
        @(negedge clk);
        bus_if.nonce_init = 32'h2222_2222;
        for (int h = 1; h <= 198; h++) begin
            check_cycle(h, 32'h1111_1111, 1'b1);
            @(negedge clk);
        end
        check("b2b c199 busy", 32'(bus_if.busy), 32'd0);
        check("b2b c199 nonce", bus_if.nonce_cur, 32'h1111_1111);
        check("b2b c199 select", 32'(bus_if.select), 32'd127);
        push_hash(32'h2222_2222);
        @(negedge clk);
        bus_if.start = 1'b0;
        for (int h = 1; h <= 198; h++) begin
            check_cycle(h, 32'h2222_2222, 1'b1);
            @(negedge clk);
        end
        check("b2b end busy", 32'(bus_if.busy), 32'd0);
        check("b2b sb_empty", 32'(exp_q.size()), 32'd0);
`else
        // Sweep from FFFFFFFE: two hashes, second with FFFFFFFF, then wrap to idle.
        push_hash(32'hFFFF_FFFE);
        bus_if.nonce_init = 32'hFFFF_FFFE;
        bus_if.start      = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        for (int h = 1; h <= 198; h++) begin
            check_cycle(h, 32'hFFFF_FFFE, 1'b1);
            @(negedge clk);
        end
        push_hash(32'hFFFF_FFFF);
        for (int h = 1; h <= 198; h++) begin
            check_cycle(h, 32'hFFFF_FFFF, 1'b1);
            @(negedge clk);
        end
        check("wrap busy", 32'(bus_if.busy), 32'd0);
        check("wrap wrapped", 32'(bus_if.wrapped), 32'd1);
        check("wrap nonce", bus_if.nonce_cur, 32'hFFFF_FFFF);
        check("wrap sb_empty", 32'(exp_q.size()), 32'd0);
        bus_if.nonce_init = 32'h0000_0005;
        bus_if.start      = 1'b1;
        @(negedge clk);
        bus_if.start = 1'b0;
        check("wrap cleared", 32'(bus_if.wrapped), 32'd0);
        check("wrap restart nonce", bus_if.nonce_cur, 32'h0000_0005);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
